seq_detect_ctrl: RTL
====================

# seq_detect_ctrl

Programmable serial-pattern detection controller. It sequences a Moore-style pattern-matching datapath: it holds the pattern configuration, arms and disarms detection, and selects overlapping or non-overlapping match semantics. It also counts matches and flags completion when a programmed match count is reached. It sits between a bit-serial source (x/x_valid) and a host or control FSM that drives the cfg/start/stop controls.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- CNT_W, 8, width of match counter and threshold
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe; accepted only in IDLE or DONE
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- cfg_thresh  in  CNT_W  match count that ends a run; 0 = run until stop
- start  in  1  pulse; arm detection and clear count
- stop  in  1  pulse; disarm, count retained
- x_valid  in  1  qualifies x
- x  in  1  serial data bit
- match  out  1  one-cycle registered pulse per detected pattern
- match_cnt  out  CNT_W  matches since last start; saturates at all-ones
- busy  out  1  high in RUN
- done  out  1  high in DONE
- cfg_err  out  1  one-cycle pulse on a rejected config write or an illegal start

## Operation
- Config registers pat, len, ovl, thr load on cfg_we in IDLE/DONE. In RUN, cfg_we is ignored and cfg_err pulses.
- FSM states IDLE, RUN, DONE (one-hot or binary, implementer's choice).
  - IDLE: start with 1<=len<=MAX_LEN → RUN; clear window, fill count and match_cnt. start with an illegal len → stay IDLE and pulse cfg_err.
  - RUN: stop → IDLE. A match with match_cnt+1 == thr (thr != 0) → DONE.
  - DONE: start → RUN, with the same clears as from IDLE. stop → IDLE.
  - If start and stop occur in the same cycle, stop wins.
- Datapath (RUN only; x_valid is ignored elsewhere):
  - On x_valid, the window shifts: w <= {w[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - A match occurs when the new fill >= len and the new w[len-1:0] == pat[len-1:0].
- On a match:
  - match is registered high for the next cycle.
  - match_cnt increments, saturating at 2^CNT_W-1.
  - Non-overlap mode sets fill to 0, so the next match needs len fresh bits. Overlap mode leaves fill unchanged.
- match is Moore-style: it depends only on registered state, and there is no combinational path from x to any output.
- Reset values: FSM IDLE; match=0, match_cnt=0, busy=0, done=0, cfg_err=0; pat=0, len=0, ovl=0, thr=0; w=0, fill=0.

## Timing
- Match latency: the bit that completes the pattern is sampled at edge N. match is high from edge N to edge N+1, and match_cnt updates at edge N.
- Back-to-back matches (overlap with len=1, or a periodic pattern) produce consecutive match cycles with no gap.
- busy and done change on the edge after start, stop or the threshold match. done rises on the same edge that match rises for the threshold match.
- stop in the same cycle as a completing x_valid: the bit is discarded, with no match and no count change.
- The bit completing the threshold match is the last one consumed. x_valid in DONE is ignored.
- cfg_err is high for exactly one cycle per offending event.
- rst_n asserted mid-run: all state clears immediately (asynchronous). Detection resumes only after a new config write and start.

## Test plan
- Reset: hold rst_n=0 mid-RUN with x toggling → all outputs 0 and FSM IDLE while asserted; after release, x_valid produces no match.
- Non-overlap: pat=4'b1010, len=4, ovl=0, thr=0; start; stream 1,0,1,0,1,0,0 → exactly one match, one cycle after bit 4; match_cnt=1.
- Overlap: same stream with ovl=1 → matches one cycle after bits 4 and 6; match_cnt=2. With len=1, pat=1 and stream 1,1,1 → three consecutive match cycles.
- Threshold: ovl=1, thr=2, stream 1010101010 → done rises with the second match, busy falls, match_cnt=2, and later bits are ignored. A new start clears the count and re-enters RUN.
- Errors: cfg_we during RUN → cfg_err pulse and the config is unchanged. len=0 then start → cfg_err pulse and the FSM stays IDLE. Simultaneous start and stop in RUN → IDLE.
- Saturation and gaps: CNT_W=2, ovl=1, len=1, pat=1, thr=0, seven 1s with random x_valid gaps → match_cnt sticks at 3, and the match count equals the number of valid 1s.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial-pattern detection controller
// Arms a shift-window matcher on start, counts matches and stops at a programmable threshold.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_thresh,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         x_valid,
  input  logic                         x,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [CNT_W-1:0]   thr;
  // The oldest window bit is shifted out before it can ever be compared, so it is not stored.
  logic [MAX_LEN-2:0] w;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] w_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_next;
  logic [CNT_W:0]     cnt_inc;
  logic               len_ok;
  logic               hit;
  logic               thr_hit;

  always_comb begin
    w_next    = {w, x};
    fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (LEN_W'(i) < len);
    hit       = (fill_next >= len) && (((w_next ^ pat) & len_mask) == '0);
    cnt_inc   = {1'b0, match_cnt} + {{CNT_W{1'b0}}, 1'b1};
    // The extra counter bit keeps a saturated count from wrapping onto the threshold.
    thr_hit   = (thr != '0) && (cnt_inc == {1'b0, thr});
    len_ok    = (len != '0) && (len <= LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match     <= 1'b0;
      match_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      pat       <= '0;
      len       <= '0;
      ovl       <= 1'b0;
      thr       <= '0;
      w         <= '0;
      fill      <= '0;
    end else begin
      match   <= 1'b0;
      cfg_err <= 1'b0;

      if (cfg_we) begin
        if (state == RUN) begin
          cfg_err <= 1'b1;
        end else begin
          pat <= cfg_pattern;
          len <= cfg_len;
          ovl <= cfg_overlap;
          thr <= cfg_thresh;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (start) begin
            if (len_ok) begin
              state     <= RUN;
              busy      <= 1'b1;
              done      <= 1'b0;
              w         <= '0;
              fill      <= '0;
              match_cnt <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        RUN: begin
          // stop outranks both start and a bit arriving in the same cycle.
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (x_valid) begin
            w    <= w_next[MAX_LEN-2:0];
            fill <= (hit && !ovl) ? '0 : fill_next;
            if (hit) begin
              match <= 1'b1;
              if (!cnt_inc[CNT_W]) match_cnt <= cnt_inc[CNT_W-1:0];
              if (thr_hit) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
